cond_logic: RTL and testbench

Execute-stage condition unit for the pipelined ARM core. It holds the architectural NZCV flag register and captures the ALU's `{neg, zero, carry, over}` flag vector when a flag-setting instruction commits. It evaluates the 4-bit ARM condition field against the stored flags. It gates the instruction's register-write, memory-write and PC-write requests, so that instructions whose condition fails retire as no-ops.

---
 rtl/cond_logic_if.sv | 26 ++
 rtl/cond_logic.sv | 66 ++++++
 tb/tb_cond_logic.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cond_logic_if.sv
// Execute-stage condition bundle: instruction requests in, gated writes and flags out.
interface cond_logic_if;
    logic       Valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       CondEx;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    modport master (
        output Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags
    );

    modport slave (
        input  Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output CondEx, PCSrc, RegWrite, MemWrite, Flags
    );
endinterface

// File: rtl/cond_logic.sv
// ARM condition unit: holds NZCV, evaluates the condition field against it,
// and gates register/memory/PC writes so failed instructions retire as no-ops.
module cond_logic (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_pass;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Evaluated on registered flags only; 1111 behaves as AL.
    always_comb begin
        cond_pass = 1'b1;
        case (bus.Cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~c_f | z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = ~z_f & (n_f == v_f);
            4'b1101: cond_pass = z_f | (n_f != v_f);
            default: cond_pass = 1'b1;
        endcase
    end

    // Valid gates last so an unknown Cond during a bubble cannot leak out.
    assign cond_ex = bus.Valid & cond_pass;

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex;
    assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemW & cond_ex;
    assign bus.Flags    = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (bus.FlagW[1] && cond_ex) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
        end
        if (bus.FlagW[0] && cond_ex) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: stimulus pushes expected {CondEx,PCSrc,RegWrite,MemWrite}
// and Flags per cycle; a negedge monitor pops and compares.
module tb_cond_logic;

    typedef struct {
        string      nm;
        logic [3:0] o;
        logic [3:0] f;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;
    logic [3:0] cur_flags;

    cond_logic_if bus ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'b000:  base = z;
            3'b001:  base = cy;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = cy & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
    endfunction

    // One cycle of stimulus; e_out = {CondEx,PCSrc,RegWrite,MemWrite}, e_f = Flags seen this cycle.
    task automatic step(input string nm, input logic rst_v, input logic mid_rst,
                        input logic v, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs, input logic regw,
                        input logic memw, input logic nowr,
                        input logic [3:0] e_out, input logic [3:0] e_f);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst_v;
        bus.Valid    = v;
        bus.Cond     = c;
        bus.ALUFlags = af;
        bus.FlagW    = fw;
        bus.PCS      = pcs;
        bus.RegW     = regw;
        bus.MemW     = memw;
        bus.NoWrite  = nowr;
        if (mid_rst) begin
            #2;
            reset = 1'b1;
        end
        e.nm = nm;
        e.o  = e_out;
        e.f  = e_f;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0] act_o;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act_o = {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite};
                n_tests++;
                if (act_o !== e.o || bus.Flags !== e.f) begin
                    n_fail++;
                    $display("FAIL %s: outs=%b flags=%b, expected outs=%b flags=%b",
                             e.nm, act_o, bus.Flags, e.o, e.f);
                end
            end
        end
    end

    initial begin : stim
        n_tests = 0;
        n_fail  = 0;
        reset        = 1'b1;
        bus.Valid    = 1'b0;
        bus.Cond     = 4'b0000;
        bus.ALUFlags = 4'b0000;
        bus.FlagW    = 2'b00;
        bus.PCS      = 1'b0;
        bus.RegW     = 1'b0;
        bus.MemW     = 1'b0;
        bus.NoWrite  = 1'b0;

        //    name         rst mid v  cond     alu      fw     pcs rw mw nw  out      flags
        step("rst_hold",   1, 0, 1, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0, 4'b1010, 4'b0000);
        step("rst_discard",0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b0000);
        step("set_all",    0, 0, 1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 4'b1000, 4'b0000);
        step("pre_rst",    0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b1111);
        step("async_rst",  0, 1, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 4'b0000, 4'b0000);
        step("rst_ne",     1, 0, 1, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 4'b1010, 4'b0000);
        step("rst_eq",     1, 0, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 4'b0000, 4'b0000);

        step("cmp",        0, 0, 1, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1, 4'b1000, 4'b0000);
        step("beq",        0, 0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b1100, 4'b0100);
        step("bne",        0, 0, 1, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b0100);

        step("set_0011",   0, 0, 1, 4'b1110, 4'b0011, 2'b11, 0, 0, 0, 0, 4'b1000, 4'b0100);
        step("split_hi",   0, 0, 1, 4'b1110, 4'b1100, 2'b10, 0, 0, 0, 0, 4'b1000, 4'b0011);
        step("split_lo",   0, 0, 1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0, 4'b1000, 4'b1111);
        step("split_chk",  0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b1100);

        step("clr",        0, 0, 1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 4'b1000, 4'b1100);
        step("fail_cond",  0, 0, 1, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0, 4'b0000, 4'b0000);
        step("fail_chk",   0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0000, 4'b0000);

        // Conditional flag-setters test the old flags, then write new ones.
        step("addsne",     0, 0, 1, 4'b0001, 4'b0100, 2'b11, 0, 1, 0, 0, 4'b1010, 4'b0000);
        step("addseq",     0, 0, 1, 4'b0000, 4'b0000, 2'b11, 0, 1, 0, 0, 4'b1010, 4'b0100);
        step("post_eq",    0, 0, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 4'b0000, 4'b0000);

        step("bubble",     0, 0, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 4'b0000, 4'b0000);
        step("bubble_x",   0, 0, 0, 4'bxxxx, 4'b1111, 2'b11, 1, 1, 1, 0, 4'b0000, 4'b0000);
        step("unbubble",   0, 0, 1, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 4'b1111, 4'b0000);

        cur_flags = 4'b0000;
        for (int f = 0; f < 16; f++) begin
            step("sweep_set", 0, 0, 1, 4'b1110, f[3:0], 2'b11, 0, 0, 0, 0, 4'b1000, cur_flags);
            cur_flags = f[3:0];
            for (int c = 0; c < 16; c++) begin
                logic r;
                r = ref_cond(c[3:0], cur_flags);
                step($sformatf("sweep_c%0d_f%0d", c, f), 0, 0, 1, c[3:0], 4'b0000, 2'b00,
                     0, 1, 0, 0, {r, 1'b0, r, 1'b0}, cur_flags);
            end
        end

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
